// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and the word type held in the response buffer.
package if_stage_pkg;

  localparam int XLEN         = 32;
  localparam int IF_BUF_DEPTH = 2;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO; flush empties it in one cycle, head is the oldest entry.
module fetch_fifo
  import if_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [IF_BUF_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign do_push = push && ((count_q != 2'(IF_BUF_DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffering
// and the IF/ID pipeline register, with redirect that drops all wrong-path words.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            take_branch,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_IR,
  output logic [XLEN-1:0] if_id_PC,
  output logic [XLEN-1:0] if_id_NPC,
  output logic            if_id_valid_inst
);

  // imem handshake: a request is accepted in the cycle where imem_req and
  // imem_gnt are both high; each accepted request gets exactly one
  // imem_rvalid pulse, in order, no earlier than the following cycle.
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      outst_q, outst_d;
  logic [1:0]      drop_q, drop_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            valid_q, valid_d;

  logic            grant, rsp, deliver, advance;
  logic            buf_empty, buf_push, buf_pop, bypass;
  logic [1:0]      pcq_cnt, buf_cnt;
  logic [XLEN-1:0] pcq_head;
  fetch_word_t     buf_din, buf_head;

  assign imem_req  = !take_branch && (({1'b0, outst_q} + {1'b0, buf_cnt}) < 3'd2);
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing outstanding is left over from before reset.
  assign rsp       = imem_rvalid && (outst_q != 2'd0);
  assign deliver   = rsp && (drop_q == 2'd0) && !take_branch;

  assign advance   = !stall || !valid_q;
  assign buf_empty = (buf_cnt == 2'd0);
  assign buf_pop   = advance && !buf_empty && !take_branch;
  assign bypass    = advance && buf_empty && deliver;
  assign buf_push  = deliver && !bypass;
  assign buf_din   = '{ir: imem_rdata, pc: pcq_head};

  fetch_fifo #(.WIDTH(XLEN)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (rsp),
    .flush (1'b0),
    .din   (pc_q),
    .count (pcq_cnt),
    .head  (pcq_head)
  );

  fetch_fifo #(.WIDTH(2 * XLEN)) u_rsp_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .flush (take_branch),
    .din   (buf_din),
    .count (buf_cnt),
    .head  (buf_head)
  );

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + {1'b0, grant} - {1'b0, rsp};
    drop_d  = drop_q;
    if (take_branch) begin
      pc_d   = branch_target;
      drop_d = outst_q - {1'b0, rsp};
    end else begin
      if (grant) pc_d = next_pc(pc_q);
      if (rsp && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
    end
  end

  always_comb begin
    ir_d    = ir_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    if (take_branch) begin
      ir_d    = NOP_INST;
      valid_d = 1'b0;
    end else if (advance) begin
      if (!buf_empty) begin
        ir_d    = buf_head.ir;
        id_pc_d = buf_head.pc;
        valid_d = 1'b1;
      end else if (deliver) begin
        ir_d    = imem_rdata;
        id_pc_d = pcq_head;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= 2'd0;
      drop_q  <= 2'd0;
      ir_q    <= NOP_INST;
      id_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      ir_q    <= ir_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
    end
  end

  assign if_id_IR         = ir_q;
  assign if_id_PC         = id_pc_q;
  assign if_id_NPC        = next_pc(id_pc_q);
  assign if_id_valid_inst = valid_q;

  a_counts: assert property (@(posedge clk) disable iff (rst)
    (outst_q <= 2'd2) && (buf_cnt <= 2'd2) && (pcq_cnt == outst_q));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(buf_push && (buf_cnt == 2'd2) && !buf_pop));

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomised checks of the fetch stage against a PC-stream model
// and a variable-latency instruction memory model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, take_branch;
  logic [31:0] branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_IR, if_id_PC, if_id_NPC;
  logic        if_id_valid_inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .take_branch      (take_branch),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_NPC        (if_id_NPC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // memory model state
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cyc, lat_lo, lat_hi, stray_n;

  // scoreboard state
  logic [31:0] exp_pc;
  int          n_inst;
  logic        p_valid, p_stall, p_br, last_req, mon_on, found;
  logic [31:0] p_tgt, p_ir, p_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic mem_drive();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (stray_n > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      stray_n--;
    end else if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
  endtask

  task automatic monitor();
    if (p_br) begin
      check("br_valid", 32'(if_id_valid_inst), 32'd0);
      check("br_ir", if_id_IR, NOP);
      check("br_addr", imem_addr, p_tgt);
      exp_pc = p_tgt;
    end else if (!p_stall || !p_valid) begin
      if (if_id_valid_inst) begin
        check("if_pc", if_id_PC, exp_pc);
        check("if_ir", if_id_IR, instr_of(exp_pc));
        check("if_npc", if_id_NPC, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_inst++;
      end
    end else begin
      check("hold_valid", 32'(if_id_valid_inst), 32'd1);
      check("hold_pc", if_id_PC, p_pc);
      check("hold_ir", if_id_IR, p_ir);
    end
  endtask

  // Inputs for the current cycle are already applied; advance one clock.
  task automatic step();
    @(negedge clk);
    last_req = imem_req;
    p_valid  = if_id_valid_inst;
    p_stall  = stall;
    p_br     = take_branch;
    p_tgt    = branch_target;
    p_ir     = if_id_IR;
    p_pc     = if_id_PC;
    if (!rst && imem_req && imem_gnt) begin
      check("inflight_le2", 32'(mem_addr_q.size() < 2), 32'd1);
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_drive();
    if (mon_on && !rst) monitor();
  endtask

  task automatic do_reset(input int nstray);
    rst = 1'b1;
    imem_gnt = 1'b0;
    stall = 1'b0;
    take_branch = 1'b0;
    branch_target = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    mem_addr_q.delete();
    mem_due_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    exp_pc = RST_PC;
    stray_n = nstray;
    mem_drive();
    mon_on = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    mon_on = 1'b0;
    stray_n = 0;
    n_inst = 0;
    lat_lo = 1;
    lat_hi = 1;

    // 1: reset values and straight-line fetch, L = 1
    do_reset(0);
    check("rst_if_pc", if_id_PC, 32'h0);
    check("rst_npc", if_id_NPC, 32'h4);
    check("rst_ir", if_id_IR, NOP);
    check("rst_valid", 32'(if_id_valid_inst), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_req", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    step();
    check("t1_c1_valid", 32'(if_id_valid_inst), 32'd0);
    step();
    check("t1_c2_pc", if_id_PC, 32'h100);
    check("t1_c2_valid", 32'(if_id_valid_inst), 32'd1);
    step();
    check("t1_c3_pc", if_id_PC, 32'h104);
    step();
    check("t1_c4_pc", if_id_PC, 32'h108);

    // 2: stall for four cycles with L = 1
    stall = 1'b1;
    step();
    check("t2_req_s0", 32'(last_req), 32'd1);
    check("t2_hold_pc", if_id_PC, 32'h108);
    step();
    check("t2_req_s1", 32'(last_req), 32'd0);
    step();
    check("t2_req_s2", 32'(last_req), 32'd0);
    step();
    check("t2_req_s3", 32'(last_req), 32'd0);
    check("t2_hold_pc2", if_id_PC, 32'h108);
    stall = 1'b0;
    step();
    check("t2_req_rel", 32'(last_req), 32'd0);
    check("t2_pc_a", if_id_PC, 32'h10C);
    step();
    check("t2_pc_b", if_id_PC, 32'h110);
    step();
    check("t2_pc_c", if_id_PC, 32'h114);
    step();
    check("t2_pc_d", if_id_PC, 32'h118);

    // 3: redirect with two fetches in flight, L = 3
    lat_lo = 3;
    lat_hi = 3;
    do_reset(0);
    imem_gnt = 1'b1;
    step();
    step();
    take_branch = 1'b1;
    branch_target = 32'h200;
    step();
    take_branch = 1'b0;
    check("t3_addr", imem_addr, 32'h200);
    check("t3_valid_t1", 32'(if_id_valid_inst), 32'd0);
    step();
    step();
    check("t3_valid_mid", 32'(if_id_valid_inst), 32'd0);
    step();
    step();
    step();
    check("t3_pc", if_id_PC, 32'h200);
    check("t3_valid", 32'(if_id_valid_inst), 32'd1);
    step();
    check("t3_pc2", if_id_PC, 32'h204);

    // 4: branch and stall together while IF/ID holds a valid instruction
    stall = 1'b1;
    take_branch = 1'b1;
    branch_target = 32'h300;
    #1;
    check("t4_req_br", 32'(imem_req), 32'd0);
    step();
    check("t4_valid", 32'(if_id_valid_inst), 32'd0);
    check("t4_ir", if_id_IR, NOP);
    stall = 1'b0;
    take_branch = 1'b0;
    repeat (4) step();
    check("t4_pc", if_id_PC, 32'h300);
    check("t4_valid2", 32'(if_id_valid_inst), 32'd1);

    // 5: asynchronous reset with two requests outstanding, then stray responses
    do_reset(0);
    imem_gnt = 1'b1;
    step();
    step();
    check("t5_req_before", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_async_addr", imem_addr, RST_PC);
    check("t5_async_req", 32'(imem_req), 32'd1);
    lat_lo = 1;
    lat_hi = 1;
    do_reset(2);
    check("t5_first_req", 32'(imem_req), 32'd1);
    step();
    step();
    check("t5_valid_strays", 32'(if_id_valid_inst), 32'd0);
    imem_gnt = 1'b1;
    step();
    step();
    check("t5_pc", if_id_PC, RST_PC);
    check("t5_ir", if_id_IR, instr_of(RST_PC));
    check("t5_valid", 32'(if_id_valid_inst), 32'd1);

    // 6: random grant, latency, stall and redirects
    lat_lo = 1;
    lat_hi = 4;
    do_reset(0);
    n_inst = 0;
    for (int i = 0; i < 1500; i++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      take_branch = ($urandom_range(0, 19) == 0);
      branch_target = 32'h0000_1000 + ($urandom_range(0, 1023) << 2);
      step();
    end
    take_branch = 1'b0;
    stall = 1'b0;
    imem_gnt = 1'b1;
    lat_lo = 1;
    lat_hi = 1;
    repeat (20) step();
    check("t6_progress", 32'(n_inst >= 100), 32'd1);

    // 7: PC wraps modulo 2^32
    take_branch = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    step();
    take_branch = 1'b0;
    found = 1'b0;
    repeat (10) begin
      step();
      if (if_id_valid_inst && if_id_PC == 32'h0) found = 1'b1;
    end
    check("t7_wrap_seen", 32'(found), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
